// File: rtl/io_buf_pkg.sv
// io_buf_pkg
// Shared constants and helpers for the motor pad buffer bank.
//   MIN_SYNC_STAGES   : shallowest legal input synchronizer depth.
//   en_next()         : next value of a pad's turnaround-qualified drive enable.
package io_buf_pkg;

    localparam int unsigned MIN_SYNC_STAGES = 2;

    // A pad may drive only after oen has been low at two consecutive edges
    // (this one and the previous one, remembered in req) and no global
    // tristate request is present at this edge.
    function automatic logic en_next(input logic oen_bit,
                                     input logic req_bit,
                                     input logic force_bit);
        return ~oen_bit & req_bit & ~force_bit;
    endfunction

endpackage

// File: rtl/io_buf_sync.sv
// io_sync
// Plain flop-chain synchronizer for one pad input. No filtering.
//   clk  : clock
//   srst : synchronous active-high reset, loads every stage with RX_IDLE
//   d    : asynchronous pad level
//   q    : level after SYNC_STAGES edges
module io_sync
    import io_buf_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = MIN_SYNC_STAGES,
    parameter logic        RX_IDLE     = 1'b1
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            chain_reg <= {SYNC_STAGES{RX_IDLE}};
        end else begin
            chain_reg <= {chain_reg[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain_reg[SYNC_STAGES-1];

endmodule

// File: rtl/io_buf.sv
// io_buf
// Registered bidirectional pad bank for the motor pads (IOBUF semantics).
// Registers output data and enable, inserts a one-cycle break-before-make
// gap whenever a pad is enabled, and synchronizes the pad level back in.
//   wb_clk_i     : clock
//   wb_rst_i     : synchronous active-high reset
//   i            : per-pad data to drive
//   oen          : per-pad active-low output-enable request
//   force_hiz    : global tristate request, gates every pad immediately
//   io           : physical pads
//   o            : raw combinational pad read-back
//   o_sync       : pad level after the SYNC_STAGES synchronizer
//   drive_active : effective drive enable applied to each pad
module io_buf
    import io_buf_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = MIN_SYNC_STAGES,
    parameter logic        RX_IDLE     = 1'b1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] i,
    input  logic [WIDTH-1:0] oen,
    input  logic             force_hiz,
    inout  wire  [WIDTH-1:0] io,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] drive_active
);

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] req_reg;
    logic [WIDTH-1:0] en_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pad
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    out_reg[gi] <= 1'b0;
                    req_reg[gi] <= 1'b0;
                    en_reg[gi]  <= 1'b0;
                end else begin
                    out_reg[gi] <= i[gi];
                    req_reg[gi] <= ~oen[gi];
                    // force_hiz also clears the enable so the pad goes
                    // through the turnaround path again once it drops.
                    en_reg[gi]  <= en_next(oen[gi], req_reg[gi], force_hiz);
                end
            end

            // force_hiz gates combinationally so Hi-Z is immediate.
            assign drive_active[gi] = en_reg[gi] & ~force_hiz;

`ifdef GOWIN_IOBUF
            IOBUF u_iobuf (
                .O   (o[gi]),
                .IO  (io[gi]),
                .I   (out_reg[gi]),
                .OEN (~drive_active[gi])
            );
`else
            assign io[gi] = drive_active[gi] ? out_reg[gi] : 1'bz;
            assign o[gi]  = io[gi];
`endif

            io_sync #(
                .SYNC_STAGES (SYNC_STAGES),
                .RX_IDLE     (RX_IDLE)
            ) u_sync (
                .clk  (wb_clk_i),
                .srst (wb_rst_i),
                .d    (o[gi]),
                .q    (o_sync[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_io_buf.sv
module tb_io_buf;

    localparam int W = 4;
    localparam int S = 2;
    localparam logic IDLE = 1'b1;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] i_v;
    logic [W-1:0] oen_v;
    logic         force_v;
    logic [W-1:0] ext_en;
    logic [W-1:0] ext_val;
    wire  [W-1:0] pad;
    logic [W-1:0] o_v;
    logic [W-1:0] o_sync_v;
    logic [W-1:0] drive_v;

    int total = 0;
    int bad   = 0;

    // Reference model state: what the pad bank should present, derived from
    // the behavioural rules (data delay, run length of low oen, history of
    // sampled pad levels).
    logic [W-1:0] m_out;
    logic [W-1:0] m_en;
    int           m_run [W];
    logic [W-1:0] m_hist [S];

    always #5 clk = ~clk;

    genvar gk;
    generate
        for (gk = 0; gk < W; gk++) begin : g_ext
            assign pad[gk] = ext_en[gk] ? ext_val[gk] : 1'bz;
        end
    endgenerate

    io_buf #(.WIDTH(W), .SYNC_STAGES(S), .RX_IDLE(IDLE)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .i            (i_v),
        .oen          (oen_v),
        .force_hiz    (force_v),
        .io           (pad),
        .o            (o_v),
        .o_sync       (o_sync_v),
        .drive_active (drive_v)
    );

    function automatic logic [W-1:0] exp_drive();
        return m_en & ~{W{force_v}};
    endfunction

    function automatic logic [W-1:0] exp_o();
        logic [W-1:0] d;
        d = exp_drive();
        return (d & m_out) | (~d & ext_val);
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".drive_active"}, drive_v, exp_drive());
        chk({tag, ".o"}, o_v, exp_o());
        chk({tag, ".o_sync"}, o_sync_v, m_hist[S-1]);
        $display("t=%0t %s rst=%b i=%b oen=%b force=%b drive=%b o=%b o_sync=%b",
                 $time, tag, rst, i_v, oen_v, force_v, drive_v, o_v, o_sync_v);
    endtask

    // External driver takes over exactly the pads the model says are released.
    task automatic settle(input string tag);
        #1;
        ext_en = ~exp_drive();
        #1;
        check_all(tag);
    endtask

    task automatic tick(input string tag);
        logic [W-1:0] lvl;
        lvl = exp_o();
        @(posedge clk);
        if (rst) begin
            m_out = '0;
            m_en  = '0;
            for (int k = 0; k < W; k++) m_run[k] = 0;
            for (int s = 0; s < S; s++) m_hist[s] = {W{IDLE}};
        end else begin
            for (int s = S - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
            m_hist[0] = lvl;
            m_out = i_v;
            for (int k = 0; k < W; k++) begin
                m_run[k] = oen_v[k] ? 0 : ((m_run[k] < 2) ? m_run[k] + 1 : 2);
                m_en[k]  = (m_run[k] >= 2) && !force_v;
            end
        end
        #1;
        ext_en = ~exp_drive();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst     = 1'b1;
        i_v     = 4'b1111;
        oen_v   = 4'b0000;
        force_v = 1'b0;
        ext_en  = 4'b1111;
        ext_val = 4'b0000;
        m_out = '0; m_en = '0;
        for (int k = 0; k < W; k++) m_run[k] = 0;
        for (int s = 0; s < S; s++) m_hist[s] = {W{IDLE}};

        // Reset with oen low and i all ones: pads stay released.
        tick("reset0");
        tick("reset1");
        tick("reset2");
        chk("reset.o_sync_idle", o_sync_v, 4'b1111);
        chk("reset.drive_zero", drive_v, 4'b0000);

        // Release: first drive after the second edge.
        rst = 1'b0;
        tick("release1");
        chk("release1.not_yet", drive_v, 4'b0000);
        tick("release2");
        chk("release2.drives", o_v, 4'b1111);
        tick("release3");
        tick("release4");

        // Turnaround on pad0 with an external pull-up.
        oen_v = 4'b0001; ext_val = 4'b1111; settle("ta.setup");
        tick("ta.off1");
        tick("ta.off2");
        chk("ta.pull", o_v[0] ? 4'b0001 : 4'b0000, 4'b0001);
        oen_v = 4'b0000; i_v = 4'b1110;
        tick("ta.gap");
        chk("ta.gap_released", {3'b0, drive_v[0]}, 4'b0000);
        tick("ta.drive");
        chk("ta.driving0", {3'b0, o_v[0]}, 4'b0000);
        tick("ta.sync1");
        tick("ta.sync2");
        chk("ta.o_sync0", {3'b0, o_sync_v[0]}, 4'b0000);

        // Disable pad0 while driving 1, then an external 0.
        i_v = 4'b1111; tick("dis.d1");
        oen_v = 4'b0001; ext_val = 4'b0000;
        tick("dis.off");
        chk("dis.released", {3'b0, drive_v[0]}, 4'b0000);
        tick("dis.s1");
        tick("dis.s2");

        // force_hiz pulse while all pads drive.
        oen_v = 4'b0000; tick("fh.a"); tick("fh.b"); tick("fh.c");
        ext_val = 4'b0101;
        force_v = 1'b1; settle("fh.same_cycle");
        chk("fh.all_released", drive_v, 4'b0000);
        tick("fh.edge");
        force_v = 1'b0; settle("fh.dropped");
        tick("fh.redrive");
        chk("fh.redrive_all", drive_v, 4'b1111);

        // Chatter on pad2.
        for (int n = 0; n < 10; n++) begin
            oen_v[2] = ~oen_v[2];
            tick("chatter");
            chk("chatter.pad2_off", {1'b0, drive_v[2], 2'b0}, 4'b0000);
        end

        // Loopback pattern.
        oen_v = 4'b0000; i_v = 4'b1010;
        tick("lb.1"); tick("lb.2");
        chk("lb.o", o_v, 4'b1010);
        tick("lb.3"); tick("lb.4");
        chk("lb.o_sync", o_sync_v, 4'b1010);

        // Randomized traffic, including a mid-run reset.
        for (int n = 0; n < 300; n++) begin
            i_v     = W'($urandom);
            oen_v   = W'($urandom) & W'($urandom);
            ext_val = W'($urandom);
            force_v = ($urandom_range(0, 9) == 0);
            rst     = ($urandom_range(0, 49) == 0);
            settle("rand.in");
            tick("rand.edge");
        end
        rst = 1'b0; force_v = 1'b0;
        tick("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
